// File: rtl/dac_glitch_sequencer.sv
// Purpose: shapes a DAC voltage glitch (baseline -> glitch code -> baseline) after a trigger edge.
// Latency: first glitch code appears 2+delay cycles after the trigger edge; all outputs are registered.
// Backpressure: none; arm is honoured only in IDLE, abort wins over arm and trigger.
module dac_glitch_sequencer #(
  parameter int DELAY_W = 32,
  parameter int WIDTH_W = 16,
  parameter int DAC_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               abort,
  input  logic               trigger,
  input  logic [DELAY_W-1:0] delay,
  input  logic [WIDTH_W-1:0] width,
  input  logic [DAC_W-1:0]   base_level,
  input  logic [DAC_W-1:0]   glitch_level,
  output logic [DAC_W-1:0]   dac_level,
  output logic               busy,
  output logic               done,
  output logic               glitch_active,
  output logic [1:0]         state,
  output logic [DELAY_W-1:0] delay_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_DELAY  = 2'd2,
    S_GLITCH = 2'd3
  } state_t;

  localparam logic [DELAY_W-1:0] DCNT_ONE = DELAY_W'(1);
  localparam logic [WIDTH_W-1:0] WCNT_ONE = WIDTH_W'(1);

  state_t             state_q, state_d;
  logic               trig_q, trig_d;
  logic [DAC_W-1:0]   dac_q, dac_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               glitch_q, glitch_d;
  logic [DELAY_W-1:0] dcnt_q, dcnt_d;
  logic [WIDTH_W-1:0] wcnt_q, wcnt_d;
  logic [DELAY_W-1:0] delay_lat_q, delay_lat_d;
  logic [WIDTH_W-1:0] width_lat_q, width_lat_d;
  logic [DAC_W-1:0]   base_lat_q, base_lat_d;
  logic [DAC_W-1:0]   glitch_lat_q, glitch_lat_d;
  logic               trig_edge;

  // Edge is seen against the previous-cycle sample, so a trigger already high
  // on entry to ARMED must drop and rise again before it fires.
  assign trig_edge = trigger && !trig_q;

  // Next-state, counters, configuration latches and next output values.
  always_comb begin
    state_d      = state_q;
    trig_d       = trigger;
    dac_d        = dac_q;
    done_d       = 1'b0;
    glitch_d     = 1'b0;
    dcnt_d       = dcnt_q;
    wcnt_d       = wcnt_q;
    delay_lat_d  = delay_lat_q;
    width_lat_d  = width_lat_q;
    base_lat_d   = base_lat_q;
    glitch_lat_d = glitch_lat_q;

    if (abort) begin
      // From IDLE nothing is latched yet, so the live baseline is the safe code.
      state_d = S_IDLE;
      dac_d   = (state_q == S_IDLE) ? base_level : base_lat_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          dac_d = base_level;
          if (arm) begin
            delay_lat_d  = delay;
            width_lat_d  = width;
            base_lat_d   = base_level;
            glitch_lat_d = glitch_level;
            state_d      = S_ARMED;
          end
        end
        S_ARMED: begin
          dac_d = base_lat_q;
          if (trig_edge) begin
            state_d = S_DELAY;
            dcnt_d  = '0;
          end
        end
        S_DELAY: begin
          dac_d = base_lat_q;
          if (dcnt_q == delay_lat_q) begin
            if (width_lat_q == '0) begin
              // Zero width: no glitch at all, just report completion.
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = S_GLITCH;
              dac_d    = glitch_lat_q;
              glitch_d = 1'b1;
              wcnt_d   = WCNT_ONE;
            end
          end else if (dcnt_q != '1) begin
            dcnt_d = dcnt_q + DCNT_ONE;
          end
        end
        S_GLITCH: begin
          // wcnt_q counts glitch cycles already on the pins, including this one.
          if (wcnt_q == width_lat_q) begin
            state_d = S_IDLE;
            dac_d   = base_lat_q;
            done_d  = 1'b1;
          end else begin
            dac_d    = glitch_lat_q;
            glitch_d = 1'b1;
            wcnt_d   = wcnt_q + WCNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          dac_d   = base_level;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset forces the DAC to 0 without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      trig_q       <= 1'b0;
      dac_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      glitch_q     <= 1'b0;
      dcnt_q       <= '0;
      wcnt_q       <= '0;
      delay_lat_q  <= '0;
      width_lat_q  <= '0;
      base_lat_q   <= '0;
      glitch_lat_q <= '0;
    end else begin
      state_q      <= state_d;
      trig_q       <= trig_d;
      dac_q        <= dac_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      glitch_q     <= glitch_d;
      dcnt_q       <= dcnt_d;
      wcnt_q       <= wcnt_d;
      delay_lat_q  <= delay_lat_d;
      width_lat_q  <= width_lat_d;
      base_lat_q   <= base_lat_d;
      glitch_lat_q <= glitch_lat_d;
    end
  end

  assign dac_level     = dac_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign glitch_active = glitch_q;
  assign state         = state_q;
  assign delay_count   = dcnt_q;

endmodule
